loop_bank_ctrl: RTL

//  Parametrised looper transport controller for NUM_BANKS record/play banks; successor to the 8-bank controller.

---
 rtl/loop_pkg.sv | 31 +++
 rtl/loop_hold_timer.sv | 28 ++
 rtl/loop_bank_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_pkg.sv
// Shared definitions for the looper transport controller.
// Contents: FSM state type, button bit positions within btns,
// and a modulo-add helper used for bank index arithmetic.
package loop_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BTN_REL,
    ST_PLAY,
    ST_RECORD,
    ST_REC_ARMED,
    ST_STOP_HOLD,
    ST_DELETE,
    ST_DEL_WAIT,
    ST_PURGE
  } state_t;

  localparam logic [1:0] BTN_BACK = 2'd0;
  localparam logic [1:0] BTN_STOP = 2'd1;
  localparam logic [1:0] BTN_PLAY = 2'd2;
  localparam logic [1:0] BTN_NEXT = 2'd3;

  // (a + b) mod n, for a < n and b < n
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/loop_hold_timer.sv
// Stop-button hold timer.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en       : count while high; counter clears whenever low
//   done     : 1-cycle pulse on the HOLD_CYCLES-th consecutive enabled cycle
module loop_hold_timer #(
  parameter int HOLD_CYCLES = 150000000,
  parameter int CNT_W       = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);

  logic [CNT_W-1:0] r_cnt;

  assign done = en && (r_cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !en || done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/loop_bank_ctrl.sv
// Looper transport controller for NUM_BANKS record/play banks.
// Converts debounced buttons into per-bank play/record/active flags, runs the
// delete req/ack handshake to the sample-memory controller and emits the
// loop-length max set/reset strobes.
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   btns[3:0]        : [0]=back [1]=stop [2]=play/record [3]=next
//   bank             : selected bank
//   playing/recording/active : per-bank flags
//   del_req/del_bank : delete request (held until del_ack) and target bank
//   del_ack          : 1-cycle erase-done acknowledge
//   cur_max          : current loop length, 0 = nothing committed yet
//   set_max/reset_max: 1-cycle loop-max strobes
//   busy             : delete or purge sequence in progress
// Build option: define LOOP_BANK_WRAP_EN to make back/next wrap around the
// bank range; otherwise bank saturates at 0 / NUM_BANKS-1.
module loop_bank_ctrl
  import loop_pkg::*;
#(
  parameter int NUM_BANKS   = 8,
  parameter int BANK_W      = $clog2(NUM_BANKS),
  parameter int MAX_W       = 23,
  parameter int HOLD_CYCLES = 150000000,
  parameter int CNT_W       = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           btns,
  output logic [BANK_W-1:0]    bank,
  output logic [NUM_BANKS-1:0] playing,
  output logic [NUM_BANKS-1:0] recording,
  output logic [NUM_BANKS-1:0] active,
  output logic                 del_req,
  output logic [BANK_W-1:0]    del_bank,
  input  logic                 del_ack,
  input  logic [MAX_W-1:0]     cur_max,
  output logic                 set_max,
  output logic                 reset_max,
  output logic                 busy
);

  localparam int OFS_W = BANK_W + 1;

  state_t                r_state, w_state_nxt;
  logic [BANK_W-1:0]     r_bank, w_bank_nxt, w_bank_inc, w_bank_dec;
  logic [NUM_BANKS-1:0]  r_playing, w_playing_nxt;
  logic [NUM_BANKS-1:0]  r_recording, w_recording_nxt;
  logic [NUM_BANKS-1:0]  r_active, w_active_nxt;
  logic                  r_del_req, w_del_req_nxt;
  logic [BANK_W-1:0]     r_del_bank, w_del_bank_nxt;
  logic                  r_set_max, w_set_max_nxt;
  logic                  r_reset_max, w_reset_max_nxt;
  logic                  r_busy;
  logic                  r_armed, w_armed_nxt;
  logic [OFS_W-1:0]      r_pofs, w_pofs_nxt;
  logic                  w_do_delete;
  logic                  w_hold_en, w_hold_done;
  logic                  w_found;
  logic [OFS_W-1:0]      w_found_ofs;
  logic [BANK_W-1:0]     w_found_idx;
  int unsigned           w_idx;

  assign w_hold_en = (r_state == ST_STOP_HOLD) && btns[BTN_STOP];

  loop_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_hold (
    .clk (clk),
    .rst (rst),
    .en  (w_hold_en),
    .done(w_hold_done)
  );

  always_comb begin
    w_bank_inc = r_bank + BANK_W'(1);
    w_bank_dec = r_bank - BANK_W'(1);
`ifdef LOOP_BANK_WRAP_EN
    if (r_bank == BANK_W'(NUM_BANKS - 1)) w_bank_inc = '0;
    if (r_bank == '0)                     w_bank_dec = BANK_W'(NUM_BANKS - 1);
`else
    if (r_bank == BANK_W'(NUM_BANKS - 1)) w_bank_inc = r_bank;
    if (r_bank == '0)                     w_bank_dec = '0;
`endif
  end

  // Purge target search: first inactive bank at offset >= r_pofs from the
  // selected bank, so active banks are skipped within the same cycle.
  always_comb begin
    w_found     = 1'b0;
    w_found_ofs = '0;
    w_found_idx = '0;
    w_idx       = 0;
    for (int unsigned k = 1; k < NUM_BANKS; k++) begin
      w_idx = wrap_add(32'(r_bank), k, NUM_BANKS);
      if (!w_found && (k >= 32'(r_pofs)) && !r_active[BANK_W'(w_idx)]) begin
        w_found     = 1'b1;
        w_found_ofs = OFS_W'(k);
        w_found_idx = BANK_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bank_nxt      = r_bank;
    w_playing_nxt   = r_playing;
    w_recording_nxt = r_recording;
    w_active_nxt    = r_active;
    w_del_req_nxt   = r_del_req;
    w_del_bank_nxt  = r_del_bank;
    w_set_max_nxt   = 1'b0;
    w_reset_max_nxt = 1'b0;
    w_armed_nxt     = r_armed;
    w_pofs_nxt      = r_pofs;
    w_do_delete     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (btns[BTN_BACK]) begin
          w_bank_nxt  = w_bank_dec;
          w_state_nxt = ST_BTN_REL;
        end else if (btns[BTN_NEXT]) begin
          w_bank_nxt  = w_bank_inc;
          w_state_nxt = ST_BTN_REL;
        end else if (btns[BTN_STOP]) begin
          w_playing_nxt[r_bank] = 1'b0;
          w_state_nxt           = ST_STOP_HOLD;
        end else if (btns[BTN_PLAY]) begin
          if (!r_active[r_bank] || r_playing[r_bank]) begin
            w_recording_nxt[r_bank] = 1'b1;
            w_playing_nxt[r_bank]   = 1'b0;
            w_state_nxt             = ST_RECORD;
          end else begin
            w_playing_nxt[r_bank]   = 1'b1;
            w_recording_nxt[r_bank] = 1'b0;
            w_state_nxt             = ST_PLAY;
          end
        end
      end
      ST_BTN_REL: begin
        if (btns == '0) w_state_nxt = ST_IDLE;
      end
      ST_PLAY: begin
        if (!btns[BTN_PLAY]) begin
          if (r_armed) begin
            w_armed_nxt = 1'b0;
            w_pofs_nxt  = OFS_W'(1);
            w_state_nxt = ST_PURGE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_RECORD: begin
        if (btns[BTN_STOP])       w_do_delete = 1'b1;
        else if (!btns[BTN_PLAY]) w_state_nxt = ST_REC_ARMED;
      end
      ST_REC_ARMED: begin
        if (btns[BTN_STOP]) begin
          w_do_delete = 1'b1;
        end else if (btns[BTN_PLAY]) begin
          w_active_nxt[r_bank]    = 1'b1;
          w_playing_nxt[r_bank]   = 1'b1;
          w_recording_nxt[r_bank] = 1'b0;
          w_state_nxt             = ST_PLAY;
          if (cur_max == '0) begin
            w_set_max_nxt = 1'b1;
            w_armed_nxt   = 1'b1;
          end
        end
      end
      ST_STOP_HOLD: begin
        if (w_hold_done)          w_do_delete = 1'b1;
        else if (!btns[BTN_STOP]) w_state_nxt = ST_IDLE;
      end
      // del_req is raised on entry to DELETE, so an ack may already arrive there.
      ST_DELETE, ST_DEL_WAIT: begin
        if (r_del_req && del_ack) begin
          w_del_req_nxt = 1'b0;
          if (r_active == '0) w_reset_max_nxt = 1'b1;
        end
        if (r_state == ST_DELETE)                   w_state_nxt = ST_DEL_WAIT;
        else if (!r_del_req && !btns[BTN_STOP])     w_state_nxt = ST_IDLE;
      end
      ST_PURGE: begin
        if (r_del_req) begin
          if (del_ack) w_del_req_nxt = 1'b0;
        end else if (w_found) begin
          w_del_req_nxt  = 1'b1;
          w_del_bank_nxt = w_found_idx;
          w_pofs_nxt     = w_found_ofs + OFS_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_do_delete) begin
      w_del_req_nxt           = 1'b1;
      w_del_bank_nxt          = r_bank;
      w_recording_nxt[r_bank] = 1'b0;
      w_active_nxt[r_bank]    = 1'b0;
      w_state_nxt             = ST_DELETE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank      <= '0;
      r_playing   <= '0;
      r_recording <= '0;
      r_active    <= '0;
      r_del_req   <= 1'b0;
      r_del_bank  <= '0;
      r_set_max   <= 1'b0;
      r_reset_max <= 1'b0;
      r_busy      <= 1'b0;
      r_armed     <= 1'b0;
      r_pofs      <= '0;
    end else begin
      r_bank      <= w_bank_nxt;
      r_playing   <= w_playing_nxt;
      r_recording <= w_recording_nxt;
      r_active    <= w_active_nxt;
      r_del_req   <= w_del_req_nxt;
      r_del_bank  <= w_del_bank_nxt;
      r_set_max   <= w_set_max_nxt;
      r_reset_max <= w_reset_max_nxt;
      r_busy      <= w_state_nxt inside {ST_DELETE, ST_DEL_WAIT, ST_PURGE};
      r_armed     <= w_armed_nxt;
      r_pofs      <= w_pofs_nxt;
    end
  end

  assign bank      = r_bank;
  assign playing   = r_playing;
  assign recording = r_recording;
  assign active    = r_active;
  assign del_req   = r_del_req;
  assign del_bank  = r_del_bank;
  assign set_max   = r_set_max;
  assign reset_max = r_reset_max;
  assign busy      = r_busy;

endmodule
